roi_crop_stream: RTL
====================

ROI_CROP_STREAM -- requirements
Module: roi_crop_stream

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 10, meaning bits per pixel.
REQ-002 SHALL have parameter PIXELS_PER_BEAT, default 4, meaning pixels packed per stream beat, with pixel 0 in the LSBs.
REQ-003 SHALL have parameters IN_ROWS 20, IN_COLS 20, OUT_ROWS 10, OUT_COLS 8, meaning input and crop frame dimensions in pixels; IN_COLS and OUT_COLS SHALL be multiples of PIXELS_PER_BEAT.
REQ-004 SHALL have one clock and one reset: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tdata  in  PIXELS_PER_BEAT*PIXEL_BIT_WIDTH; s_axis_tuser  in  1  start of frame (SOF).
REQ-007 crop_x0  in  $clog2(IN_COLS)  crop origin column; crop_y0  in  $clog2(IN_ROWS)  crop origin row.
REQ-008 m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tdata  out  PIXELS_PER_BEAT*PIXEL_BIT_WIDTH; m_axis_tuser  out  1  first output beat of frame; m_axis_tlast  out  1  last beat of each output row.
REQ-009 frame_done  out  1  one-cycle pulse when the last input beat of a frame is accepted; sof_err  out  1  one-cycle pulse on unexpected SOF.

Function
REQ-010 SHALL implement FSM states IDLE and ACTIVE.
REQ-011 In IDLE, input beats without SOF SHALL be accepted and discarded.
REQ-012 An accepted SOF beat SHALL enter ACTIVE, set row=0 and col_beat=0, and be treated as pixel (0,0).
REQ-013 On an accepted SOF beat, crop_x0 and crop_y0 SHALL be latched and held for the whole frame. Later port changes SHALL have no effect until the next SOF.
REQ-014 The latched x0 SHALL be rounded down to a multiple of PIXELS_PER_BEAT; the crop is beat-granular.
REQ-015 Latched x0 SHALL be clamped to IN_COLS-OUT_COLS and y0 to IN_ROWS-OUT_ROWS; arithmetic SHALL use widths sufficient to avoid overflow when adding OUT_ROWS or OUT_COLS.
REQ-016 A beat SHALL be forwarded iff y0 <= row < y0+OUT_ROWS and x0 <= col_beat*PIXELS_PER_BEAT < x0+OUT_COLS; otherwise it SHALL be dropped.
REQ-017 col_beat SHALL increment per accepted beat and wrap from IN_COLS/PIXELS_PER_BEAT-1 to 0, incrementing row.
REQ-018 At row IN_ROWS-1 wrap, frame_done SHALL pulse, the FSM SHALL return to IDLE, and row SHALL become 0.
REQ-019 An SOF accepted in ACTIVE other than at (0,0) SHALL pulse sof_err, resynchronise counters to (0,0), relatch crop coordinates, and forward or drop that beat per REQ-016; no frame_done pulse is issued for the aborted frame.
REQ-020 The output SHALL be a registered stage with a 2-entry skid buffer: latency 1 cycle from input acceptance to m_axis_tvalid, full throughput with m_axis_tready held high.
REQ-021 s_axis_tready SHALL be deasserted only when the skid buffer is full; dropped beats consume no buffer space.
REQ-022 m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0, with no beat lost or duplicated.
REQ-023 m_axis_tuser SHALL be 1 on the forwarded beat at (y0, x0).
REQ-024 m_axis_tlast SHALL be 1 on the forwarded beat at col_beat*PIXELS_PER_BEAT = x0+OUT_COLS-PIXELS_PER_BEAT.

Reset
REQ-025 On rst, the FSM SHALL go to IDLE; counters, latched coordinates and skid buffer SHALL clear.
REQ-026 On rst, s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, sof_err and m_axis_tdata SHALL all be 0.
REQ-027 s_axis_tready SHALL rise on the first clk edge after rst deasserts.
REQ-028 A reset mid-frame SHALL discard all buffered beats; output resumes only after a new SOF.

Structure
REQ-029 A shared package roi_crop_pkg SHALL hold the FSM state enum and a function computing the clamped, beat-aligned origin.
REQ-030 The skid buffer SHALL be a sub-module axis_skid_buffer, parametrised by data width, carrying tdata, tuser and tlast.

Verification
REQ-031 Defaults, crop (x0=4, y0=3), ramp frame with m_axis_tready=1 -> 20 beats out (10 rows x 2), first beat tuser=1 carrying pixels (3,4..7), tlast on every 2nd beat, frame_done once after 100 input beats.
REQ-032 crop_x0=18, crop_y0=15 -> clamped to x0=12, y0=10; rows 10..19, columns 12..19 output.
REQ-033 Random m_axis_tready at 30% duty -> output identical to the REQ-031 stream, no loss or duplication, data stable during stalls.
REQ-034 SOF injected at row 5 col_beat 2 -> sof_err single pulse, new frame starts with that beat at (0,0), no frame_done for the aborted frame.
REQ-035 crop_x0 changed mid-frame -> current frame unaffected, next frame uses the new value.
REQ-036 rst asserted mid-frame while stalled -> outputs 0 immediately, then non-SOF beats dropped until the next SOF.

Source files
------------

// File: rtl/roi_crop_pkg.sv
// roi_crop_pkg: shared FSM state type and crop-origin helper for the ROI crop stream.
package roi_crop_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  // Align the requested origin down to the beat grid, then keep the crop window inside the frame.
  function automatic logic [31:0] crop_origin(input logic [31:0] req, input logic [31:0] lim, input logic [31:0] align);
    logic [31:0] a;
    a = req / align * align;
    return (a > lim) ? lim : a;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry registered AXI-Stream buffer carrying data, user and last.
module axis_skid_buffer #(
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_user,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_user,
  output logic          out_last
);
  logic [DW+1:0] d0, d1, din;
  logic [1:0] cnt;
  logic push, pop;
  assign din = {in_user, in_last, in_data};
  assign in_ready = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign {out_user, out_last, out_data} = d0;
  // d0 is always the head; d1 only holds the second entry while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0 <= '0;
      d1 <= '0;
      cnt <= 2'd0;
    end else begin
      cnt <= (push && !pop) ? cnt + 2'd1 : (pop && !push) ? cnt - 2'd1 : cnt;
      if (pop) d0 <= (cnt == 2'd2) ? d1 : din;
      else if (push && cnt == 2'd0) d0 <= din;
      if (push && !pop && cnt == 2'd1) d1 <= din;
    end
  end
endmodule

// File: rtl/roi_crop_stream.sv
// roi_crop_stream: crops a beat-aligned rectangular window out of a raster pixel stream.
module roi_crop_stream
  import roi_crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int PIXELS_PER_BEAT = 4,
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       s_axis_tvalid,
  output logic                                       s_axis_tready,
  input  logic [PIXELS_PER_BEAT*PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  input  logic                                       s_axis_tuser,
  input  logic [$clog2(IN_COLS)-1:0]                 crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0]                 crop_y0,
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready,
  output logic [PIXELS_PER_BEAT*PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                                       m_axis_tuser,
  output logic                                       m_axis_tlast,
  output logic                                       frame_done,
  output logic                                       sof_err
);
  localparam int DW = PIXELS_PER_BEAT * PIXEL_BIT_WIDTH;
  localparam int CB = IN_COLS / PIXELS_PER_BEAT;
  localparam int CBW = (CB > 1) ? $clog2(CB) : 1;
  localparam int XW = $clog2(IN_COLS);
  localparam int YW = $clog2(IN_ROWS);
  state_t state, state_n;
  logic [YW-1:0] row, row_n, y0, y0_n;
  logic [CBW-1:0] col, col_n;
  logic [XW-1:0] x0, x0_n;
  logic rdy_en, sk_ready, sof, in_frame, acc, fwd, f_user, f_last, last_col, last_row, done_n, err_n;
  logic [31:0] r, c, cx, xo, yo;
  assign s_axis_tready = rdy_en & sk_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      x0 <= '0;
      y0 <= '0;
      rdy_en <= 1'b0;
      frame_done <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
      x0 <= x0_n;
      y0 <= y0_n;
      rdy_en <= 1'b1;
      frame_done <= done_n;
      sof_err <= err_n;
    end
  end
  // An SOF beat is always pixel (0,0) with freshly latched crop coordinates, in either state.
  always_comb begin
    sof = s_axis_tuser;
    acc = s_axis_tvalid & s_axis_tready;
    in_frame = sof | (state == ACTIVE);
    r = sof ? 32'd0 : 32'(row);
    c = sof ? 32'd0 : 32'(col);
    xo = sof ? crop_origin(32'(crop_x0), 32'(IN_COLS - OUT_COLS), 32'(PIXELS_PER_BEAT)) : 32'(x0);
    yo = sof ? crop_origin(32'(crop_y0), 32'(IN_ROWS - OUT_ROWS), 32'd1) : 32'(y0);
    cx = c * PIXELS_PER_BEAT;
    fwd = acc && in_frame && r >= yo && r < yo + OUT_ROWS && cx >= xo && cx < xo + OUT_COLS;
    f_user = r == yo && cx == xo;
    f_last = cx == xo + OUT_COLS - PIXELS_PER_BEAT;
    last_col = c == CB - 1;
    last_row = r == IN_ROWS - 1;
    state_n = state;
    row_n = row;
    col_n = col;
    x0_n = x0;
    y0_n = y0;
    done_n = 1'b0;
    err_n = 1'b0;
    if (acc && in_frame) begin
      x0_n = sof ? XW'(xo) : x0;
      y0_n = sof ? YW'(yo) : y0;
      err_n = sof && state == ACTIVE && (row != '0 || col != '0);
      col_n = last_col ? '0 : CBW'(c + 1);
      row_n = last_col ? (last_row ? '0 : YW'(r + 1)) : YW'(r);
      state_n = (last_col && last_row) ? IDLE : ACTIVE;
      done_n = last_col && last_row;
    end
  end
  axis_skid_buffer #(.DW(DW)) u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid(fwd),
    .in_ready(sk_ready),
    .in_data(s_axis_tdata),
    .in_user(f_user),
    .in_last(f_last),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data(m_axis_tdata),
    .out_user(m_axis_tuser),
    .out_last(m_axis_tlast)
  );
endmodule
